tim_update_ctrl: RTL and testbench
==================================

Name: tim_update_ctrl

Overview:
- Control and sequencing unit for the basic timer's prescaler datapath.
- Holds software-visible preload registers (PSC, ARR), control/status bits and the main up-counter (CNT).
- Generates update events (UEV) that transfer preload values into the shadow registers driving the prescaler, and raises the update interrupt.
- Sits between the peripheral bus register port and the prescaler counter. Consumes the prescaler overflow tick; drives the prescaler shadow value and the prescaler clear.

Parameters:
- CNT_W, 16, width of CNT, PSC and ARR registers and of wdata/rdata

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  register write strobe, single cycle
- addr  in  3  register select for read and write
- wdata  in  CNT_W  write data
- rdata  out  CNT_W  combinational read of the addressed register
- psc_tick  in  1  one-cycle pulse, prescaler overflow (counter clock enable)
- psc_shadow  out  CNT_W  active prescaler value to the prescaler counter
- psc_rst  out  1  one-cycle prescaler clear
- cnt_en  out  1  mirrors CR1.CEN
- irq  out  1  level, UIF & UIE

Behaviour:
- Register map:
  - 0 CR1: [0]CEN [1]UDIS [2]URS [3]OPM [7]ARPE
  - 1 DIER: [0]UIE
  - 2 SR: [0]UIF. Writing 0 clears; writing 1 has no effect.
  - 3 EGR: [0]UG, write-only, reads 0
  - 4 CNT: read/write
  - 5 PSC: preload
  - 6 ARR: preload
  - 7: reads 0, writes ignored
  - Unused bits read 0.
- Reset values:
  - CR1, DIER, SR, CNT, PSC, psc_shadow = 0
  - ARR and arr_shadow = all ones
  - psc_rst = 0, irq = 0
- Effective ARR (arr_act) is arr_shadow when ARPE=1, otherwise the ARR preload.
- Counting: on a posedge with psc_tick=1 and CEN=1:
  - CNT < arr_act: CNT increments.
  - CNT >= arr_act: overflow. CNT goes to 0, and a UEV is generated if UDIS=0.
- CEN used for gating is the registered value before any same-cycle write.
- UEV effects, all on the same edge:
  - psc_shadow <= PSC
  - arr_shadow <= ARR
  - UIF <= 1
  - If OPM=1, CEN <= 0.
- An overflow with UDIS=1 clears CNT only: no transfer, no flag, and OPM is not applied.
- UG write (addr 3, wdata[0]=1):
  - CNT <= 0 and psc_rst pulses high for the following cycle only.
  - If UDIS=0: shadow transfer. UIF is set only if URS=0.
  - UG does not apply OPM.
- ARR=0: CNT stays 0 and a UEV occurs on every qualifying psc_tick.
- PSC/ARR writes never affect psc_shadow or arr_shadow until the next UEV. With ARPE=0, an ARR write takes effect on the next edge.
- Simultaneous events:
  - UG write and overflow in the same cycle: exactly one UEV, UG rules apply.
  - CNT write and psc_tick in the same cycle: the written value wins.
  - SR clear and UIF set in the same cycle: set wins.
  - CR1 write and UEV with OPM in the same cycle: the OPM clear of CEN wins over the written CEN.
- rdata is combinational from registered state. Reads have no side effects.
- Reset asserted mid-count: all state returns to reset values immediately. No UEV and no psc_rst are produced by reset.

Optional Feature:
- Macro: TIM_UPDATE_DMA_EN.
- With the macro defined:
  - Adds DIER[8] UDE.
  - Adds ports dma_req (out, 1) and dma_ack (in, 1).
  - Every UEV with UDE=1 sets dma_req; it stays high until sampled with dma_ack=1, then clears on that edge.
  - A UEV coinciding with dma_ack keeps dma_req high (new request wins).
  - dma_req resets to 0.
- Without the macro:
  - No dma ports.
  - DIER[8] reads 0; writes to it are ignored.

Test Plan:
- Reset, read all addresses -> ARR=0xFFFF; CNT, PSC, CR1, SR = 0; irq=0; psc_rst=0.
- PSC=3, ARR=4, UG -> psc_shadow=3 next cycle, one psc_rst pulse, UIF=1. Clear SR, set CEN+UIE, 5 ticks -> CNT 1,2,3,4,0, UIF=1, irq=1.
- ARPE=1, ARR=9, run. Mid-period write ARR=2 -> wraps at 9 first, then every 3 ticks. With ARPE=0, the same write wraps at 2 immediately.
- OPM=1, ARR=2, CEN=1, 3 ticks -> UEV, CEN=0, cnt_en=0. Further ticks leave CNT=0.
- UDIS=1 overflow -> CNT=0, UIF stays 0, psc_shadow unchanged. URS=1 with UG -> shadow updates, UIF stays 0.
- TIM_UPDATE_DMA_EN, UDE=1, UEV -> dma_req=1 held 3 cycles until dma_ack. UEV with ack in the same cycle -> dma_req stays 1.

Source files
------------

// File: rtl/tim_update_ctrl_if.sv
// Register port between the peripheral bus and the timer update controller.
interface tim_update_ctrl_if #(parameter int CNT_W = 16);
  logic             wr_en;
  logic [2:0]       addr;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] rdata;

  modport master (output wr_en, addr, wdata, input rdata);
  modport slave  (input wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/tim_update_ctrl.sv
// Basic timer control: preload/shadow registers, up-counter, update events, irq.
// Optional update DMA request enabled by defining TIM_UPDATE_DMA_EN.
module tim_update_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  tim_update_ctrl_if.slave    bus,
  input  logic                psc_tick,
  output logic [CNT_W-1:0]    psc_shadow,
  output logic                psc_rst,
  output logic                cnt_en,
  output logic                irq
`ifdef TIM_UPDATE_DMA_EN
  ,
  output logic                dma_req,
  input  logic                dma_ack
`endif
);

  logic             cen, udis, urs, opm, arpe, uie, uif;
  logic [CNT_W-1:0] cnt, psc, arr, arr_shadow, arr_act;
  logic             wr_cr1, wr_dier, wr_sr, wr_cnt, wr_psc, wr_arr, ug;
  logic             tick, ovf, uev_ovf, uev, set_uif, opm_clr;
`ifdef TIM_UPDATE_DMA_EN
  logic             ude;
`endif

  assign wr_cr1  = bus.wr_en && (bus.addr == 3'd0);
  assign wr_dier = bus.wr_en && (bus.addr == 3'd1);
  assign wr_sr   = bus.wr_en && (bus.addr == 3'd2);
  assign ug      = bus.wr_en && (bus.addr == 3'd3) && bus.wdata[0];
  assign wr_cnt  = bus.wr_en && (bus.addr == 3'd4);
  assign wr_psc  = bus.wr_en && (bus.addr == 3'd5);
  assign wr_arr  = bus.wr_en && (bus.addr == 3'd6);

  assign arr_act = arpe ? arr_shadow : arr;
  assign tick    = psc_tick && cen;
  assign ovf     = tick && (cnt >= arr_act);
  assign uev_ovf = ovf && !udis;

  // A UG write absorbs a coincident overflow: one UEV, UG flag rules, no OPM stop.
  assign uev     = ug ? !udis : uev_ovf;
  assign set_uif = ug ? (!udis && !urs) : uev_ovf;
  assign opm_clr = !ug && uev_ovf && opm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen        <= 1'b0;
      udis       <= 1'b0;
      urs        <= 1'b0;
      opm        <= 1'b0;
      arpe       <= 1'b0;
      uie        <= 1'b0;
      uif        <= 1'b0;
      cnt        <= '0;
      psc        <= '0;
      arr        <= '1;
      psc_shadow <= '0;
      arr_shadow <= '1;
      psc_rst    <= 1'b0;
    end else begin
      if (wr_cr1) begin
        cen  <= bus.wdata[0];
        udis <= bus.wdata[1];
        urs  <= bus.wdata[2];
        opm  <= bus.wdata[3];
        arpe <= bus.wdata[7];
      end
      if (opm_clr) cen <= 1'b0;

      if (wr_dier) uie <= bus.wdata[0];

      if (set_uif)                    uif <= 1'b1;
      else if (wr_sr && !bus.wdata[0]) uif <= 1'b0;

      if (ug)          cnt <= '0;
      else if (wr_cnt) cnt <= bus.wdata;
      else if (ovf)    cnt <= '0;
      else if (tick)   cnt <= cnt + 1'b1;

      // Shadows latch the preload as it stood before any same-edge write.
      if (uev) begin
        psc_shadow <= psc;
        arr_shadow <= arr;
      end
      if (wr_psc) psc <= bus.wdata;
      if (wr_arr) arr <= bus.wdata;

      psc_rst <= ug;
    end
  end

`ifdef TIM_UPDATE_DMA_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ude     <= 1'b0;
      dma_req <= 1'b0;
    end else begin
      if (wr_dier) ude <= bus.wdata[8];
      if (uev && ude)   dma_req <= 1'b1;
      else if (dma_ack) dma_req <= 1'b0;
    end
  end
`endif

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      3'd0: bus.rdata[7:0] = {arpe, 3'b000, opm, urs, udis, cen};
      3'd1: begin
        bus.rdata[0] = uie;
`ifdef TIM_UPDATE_DMA_EN
        bus.rdata[8] = ude;
`endif
      end
      3'd2: bus.rdata[0] = uif;
      3'd4: bus.rdata = cnt;
      3'd5: bus.rdata = psc;
      3'd6: bus.rdata = arr;
      default: bus.rdata = '0;
    endcase
  end

  assign cnt_en = cen;
  assign irq    = uif && uie;

endmodule

// File: tb/tb_tim_update_ctrl.sv
// Scoreboard bench for tim_update_ctrl: directed sequences then random traffic
// checked against a cycle-level register model.
module tb_tim_update_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         psc_tick = 1'b0;
  logic [W-1:0] psc_shadow;
  logic         psc_rst, cnt_en, irq;
  logic         dma_ack_i = 1'b0;
`ifdef TIM_UPDATE_DMA_EN
  logic         dma_req;
`endif

  tim_update_ctrl_if #(.CNT_W(W)) bus ();

  tim_update_ctrl #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .psc_tick   (psc_tick),
    .psc_shadow (psc_shadow),
    .psc_rst    (psc_rst),
    .cnt_en     (cnt_en),
    .irq        (irq)
`ifdef TIM_UPDATE_DMA_EN
    ,
    .dma_req    (dma_req),
    .dma_ack    (dma_ack_i)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rd;
    logic [W-1:0] sh;
    logic         pr;
    logic         ce;
    logic         iq;
    logic         dq;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [W-1:0] m_cnt, m_psc, m_arr, m_psc_sh, m_arr_sh;
  bit m_cen, m_udis, m_urs, m_opm, m_arpe, m_uie, m_ude, m_uif, m_prst, m_dreq;

  task automatic m_reset();
    m_cnt = '0; m_psc = '0; m_arr = '1; m_psc_sh = '0; m_arr_sh = '1;
    m_cen = 0; m_udis = 0; m_urs = 0; m_opm = 0; m_arpe = 0;
    m_uie = 0; m_ude = 0; m_uif = 0; m_prst = 0; m_dreq = 0;
  endtask

  function automatic logic [W-1:0] m_read(logic [2:0] a);
    logic [W-1:0] v;
    v = '0;
    case (a)
      3'd0: begin
        v[0] = m_cen; v[1] = m_udis; v[2] = m_urs; v[3] = m_opm; v[7] = m_arpe;
      end
      3'd1: begin
        v[0] = m_uie;
`ifdef TIM_UPDATE_DMA_EN
        v[8] = m_ude;
`endif
      end
      3'd2: v[0] = m_uif;
      3'd4: v = m_cnt;
      3'd5: v = m_psc;
      3'd6: v = m_arr;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock edge of the timer, described in terms of events and their effects.
  task automatic m_step(bit wr, logic [2:0] a, logic [W-1:0] d, bit tk, bit ack);
    logic [W-1:0] limit, ncnt;
    bit is_ug, ev, flag, stop, ude_old;
    is_ug   = wr && a == 3'd3 && d[0];
    limit   = m_arpe ? m_arr_sh : m_arr;
    ude_old = m_ude;
    ncnt = m_cnt; ev = 0; flag = 0; stop = 0;
    if (tk && m_cen) begin
      if (m_cnt >= limit) begin
        ncnt = '0;
        ev   = !m_udis;
        flag = ev;
        stop = ev && m_opm;
      end else ncnt = m_cnt + 1;
    end
    if (is_ug) begin
      ncnt = '0;
      ev   = !m_udis;
      flag = !m_udis && !m_urs;
      stop = 0;
    end
    if (wr && a == 3'd4) ncnt = d;
    if (ev) begin
      m_psc_sh = m_psc;
      m_arr_sh = m_arr;
    end
    if (wr && a == 3'd0) begin
      m_cen = d[0]; m_udis = d[1]; m_urs = d[2]; m_opm = d[3]; m_arpe = d[7];
    end
    if (stop) m_cen = 0;
    if (wr && a == 3'd1) begin
      m_uie = d[0];
`ifdef TIM_UPDATE_DMA_EN
      m_ude = d[8];
`endif
    end
    if (wr && a == 3'd2 && !d[0]) m_uif = 0;
    if (flag) m_uif = 1;
    if (wr && a == 3'd5) m_psc = d;
    if (wr && a == 3'd6) m_arr = d;
    m_cnt  = ncnt;
    m_prst = is_ug;
    if (ev && ude_old) m_dreq = 1;
    else if (ack)      m_dreq = 0;
  endtask

  function automatic exp_t m_obs(logic [2:0] a);
    exp_t e;
    e.rd = m_read(a);
    e.sh = m_psc_sh;
    e.pr = m_prst;
    e.ce = m_cen;
    e.iq = m_uif && m_uie;
    e.dq = m_dreq;
    return e;
  endfunction

  // Called just after a negedge: drive inputs, log expected visible state, advance model.
  task automatic cyc(bit wr, logic [2:0] a, logic [W-1:0] d, bit tk, bit ack = 0);
    bus.wr_en = wr; bus.addr = a; bus.wdata = d; psc_tick = tk; dma_ack_i = ack;
    sbq.push_back(m_obs(a));
    m_step(wr, a, d, tk, ack);
    @(negedge clk);
  endtask

  task automatic wr(logic [2:0] a, logic [W-1:0] d);
    cyc(1, a, d, 0);
  endtask

  task automatic rd(logic [2:0] a);
    cyc(0, a, '0, 0);
  endtask

  task automatic ticks(int n, logic [2:0] a);
    for (int i = 0; i < n; i++) cyc(0, a, '0, 1);
  endtask

  task automatic async_reset();
    bus.wr_en = 0; bus.addr = 3'd4; bus.wdata = '0; psc_tick = 0; dma_ack_i = 0;
    #1 rst = 1'b1;
    m_reset();
    sbq.push_back(m_obs(3'd4));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT's visible state is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rdata",      bus.rdata,  e.rd);
        chk("psc_shadow", psc_shadow, e.sh);
        chk("psc_rst",    W'(psc_rst), W'(e.pr));
        chk("cnt_en",     W'(cnt_en),  W'(e.ce));
        chk("irq",        W'(irq),     W'(e.iq));
`ifdef TIM_UPDATE_DMA_EN
        chk("dma_req",    W'(dma_req), W'(e.dq));
`endif
      end
    end
  end

  initial begin
    logic [2:0]   a;
    logic [W-1:0] d;
    bus.wr_en = 0; bus.addr = '0; bus.wdata = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) rd(3'(i));

    // UG load then a 5-tick period
    wr(3'd5, 16'd3); wr(3'd6, 16'd4); wr(3'd3, 16'd1); rd(3'd2); rd(3'd2);
    wr(3'd2, 16'd0); wr(3'd1, 16'd1); wr(3'd0, 16'd1);
    ticks(5, 3'd4); rd(3'd2);

    // ARPE buffered vs direct ARR change
    wr(3'd2, 16'd0); wr(3'd0, 16'h0081); wr(3'd6, 16'd9); wr(3'd3, 16'd1);
    ticks(4, 3'd4); wr(3'd6, 16'd2); ticks(16, 3'd4);
    wr(3'd0, 16'h0001); wr(3'd4, 16'd0); wr(3'd6, 16'd9); ticks(4, 3'd4);
    wr(3'd6, 16'd2); ticks(5, 3'd4);

    // One-pulse mode
    wr(3'd0, 16'd0); wr(3'd4, 16'd0); wr(3'd0, 16'h0009); ticks(6, 3'd0); rd(3'd4);

    // UDIS overflow, URS with UG
    wr(3'd2, 16'd0); wr(3'd5, 16'd7); wr(3'd6, 16'd1); wr(3'd0, 16'h0003);
    ticks(4, 3'd2); rd(3'd4);
    wr(3'd0, 16'h0004); wr(3'd3, 16'd1); rd(3'd2);

    // ARR=0 and simultaneous events
    wr(3'd0, 16'd0); wr(3'd6, 16'd0); wr(3'd3, 16'd1); wr(3'd2, 16'd0);
    wr(3'd0, 16'h0001); ticks(3, 3'd4);
    cyc(1, 3'd2, 16'd0, 1); rd(3'd2);
    cyc(1, 3'd4, 16'd5, 1); rd(3'd4);
    wr(3'd6, 16'd3); wr(3'd5, 16'd2);
    cyc(1, 3'd4, 16'd3, 0); cyc(1, 3'd3, 16'd1, 1); rd(3'd4);
    wr(3'd6, 16'd0); wr(3'd0, 16'h0009); cyc(1, 3'd0, 16'h0009, 1); rd(3'd0);

    // Reset mid-count
    wr(3'd6, 16'd5); wr(3'd0, 16'h0001); ticks(3, 3'd4);
    async_reset(); rd(3'd6); rd(3'd2);

`ifdef TIM_UPDATE_DMA_EN
    wr(3'd1, 16'h0100); wr(3'd3, 16'd1); rd(3'd1); rd(3'd1); rd(3'd1);
    cyc(0, 3'd1, '0, 0, 1); rd(3'd1);
    wr(3'd3, 16'd1); rd(3'd1);
    cyc(1, 3'd3, 16'd1, 0, 1); rd(3'd1); cyc(0, 3'd1, '0, 0, 1); rd(3'd1);
`endif

    // Random traffic with small periods so overflows are frequent
    for (int i = 0; i < 3000; i++) begin
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) async_reset();
      else if ($urandom_range(0, 99) < 35) begin
        case (a)
          3'd4, 3'd5, 3'd6: d = W'($urandom_range(0, 6));
          3'd0: d = W'($urandom) & 16'h008F | W'($urandom_range(0, 1));
          default: d = W'($urandom);
        endcase
        cyc(1, a, d, 1'($urandom), 1'($urandom));
      end else
        cyc(0, a, '0, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", W'(sbq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
